// File: rtl/divide_share_arb.sv
// divide_share_arb: shares one in-order pipelined divider between NUM_REQ
// AXI-stream requesters. Packets are granted round-robin and held until
// their last beat. Each issued beat pushes its requester id into a tag FIFO
// so the in-order result stream can be steered back to the right lane.
module divide_share_arb #(
  parameter int NUM_REQ         = 2,
  parameter int MAX_OUTSTANDING = 16,
  parameter int DIVIDEND_W      = 16,
  parameter int DIVISOR_W       = 32,
  parameter int QUOT_W          = 48
) (
  input  logic                                        clk,
  input  logic                                        aresetn,
  input  logic                                        clear,
  input  logic [NUM_REQ*(DIVIDEND_W+DIVISOR_W)-1:0]   s_tdata,
  input  logic [NUM_REQ-1:0]                          s_tlast,
  input  logic [NUM_REQ-1:0]                          s_tvalid,
  output logic [NUM_REQ-1:0]                          s_tready,
  output logic [DIVIDEND_W-1:0]                       div_dividend_tdata,
  output logic [DIVISOR_W-1:0]                        div_divisor_tdata,
  output logic                                        div_tlast,
  output logic                                        div_tvalid,
  input  logic                                        div_dividend_tready,
  input  logic                                        div_divisor_tready,
  input  logic [QUOT_W-1:0]                           dout_tdata,
  input  logic                                        dout_tlast,
  input  logic                                        dout_tvalid,
  output logic                                        dout_tready,
  output logic [QUOT_W-1:0]                           m_tdata,
  output logic                                        m_tlast,
  output logic [NUM_REQ-1:0]                          m_tvalid,
  input  logic [NUM_REQ-1:0]                          m_tready,
  output logic [$clog2(MAX_OUTSTANDING):0]            outstanding,
  output logic                                        busy
);

  localparam int BEAT_W = DIVIDEND_W + DIVISOR_W;
  localparam int GW     = (NUM_REQ > 2) ? 2 : 1;
  localparam int PW     = $clog2(MAX_OUTSTANDING);
  localparam int CW     = PW + 1;

  typedef enum logic [1:0] {IDLE, LOCK, FLUSH} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   grant, grant_nxt;
  logic [GW-1:0]   rr_ptr, rr_nxt;
  logic [GW-1:0]   pick;
  logic            pick_vld;

  logic [GW-1:0]   tag_mem [MAX_OUTSTANDING];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   tag_cnt;
  logic [GW-1:0]   head;
  logic            tag_empty, tag_full, credit_ok;

  logic            issue, ret;
  logic [BEAT_W-1:0] beat;

  assign head      = tag_mem[rd_ptr];
  assign tag_empty = (tag_cnt == '0);
  assign tag_full  = (tag_cnt == CW'(MAX_OUTSTANDING));
  assign credit_ok = (outstanding < CW'(MAX_OUTSTANDING));
  assign m_tdata   = dout_tdata;
  assign m_tlast   = dout_tlast;
  assign busy      = (state != IDLE) || (outstanding != '0);

  // Round-robin search: first valid requester starting at rr_ptr, with wrap
  always_comb begin
    int unsigned idx;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_REQ;
      if (!pick_vld && s_tvalid[idx]) begin
        pick     = GW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  // Next-state, issue handshake and result steering
  always_comb begin
    state_nxt          = state;
    grant_nxt          = grant;
    rr_nxt             = rr_ptr;
    s_tready           = '0;
    div_tvalid         = 1'b0;
    div_tlast          = 1'b0;
    dout_tready        = 1'b0;
    m_tvalid           = '0;
    issue              = 1'b0;
    ret                = 1'b0;
    beat               = s_tdata[grant*BEAT_W +: BEAT_W];
    div_dividend_tdata = beat[BEAT_W-1 -: DIVIDEND_W];
    div_divisor_tdata  = beat[DIVISOR_W-1:0];

    // clear silences both handshakes this cycle so the drain count loaded
    // from outstanding matches exactly the beats still inside the divider
    if (!clear && state != FLUSH && !tag_empty) begin
      for (int unsigned i = 0; i < NUM_REQ; i++)
        m_tvalid[i] = dout_tvalid && (head == GW'(i));
      dout_tready = m_tready[head];
      ret         = dout_tvalid && dout_tready;
    end

    if (clear) begin
      state_nxt = FLUSH;
      rr_nxt    = '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant_nxt = pick;
            state_nxt = LOCK;
          end
        end
        LOCK: begin
          div_tvalid      = s_tvalid[grant] && credit_ok && !tag_full;
          div_tlast       = s_tlast[grant];
          issue           = div_tvalid && div_dividend_tready && div_divisor_tready;
          s_tready[grant] = issue;
          if (issue && s_tlast[grant]) begin
            rr_nxt    = (grant == GW'(NUM_REQ - 1)) ? '0 : grant + GW'(1);
            state_nxt = IDLE;
          end
        end
        FLUSH: begin
          dout_tready = 1'b1;
          if (outstanding == '0 || (outstanding == CW'(1) && dout_tvalid))
            state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, grant and round-robin pointer registers
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  // In-flight counter; during FLUSH it doubles as the drain count
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      outstanding <= '0;
    end else if (clear) begin
      outstanding <= outstanding;
    end else if (state == FLUSH) begin
      if (dout_tvalid && outstanding != '0)
        outstanding <= outstanding - CW'(1);
    end else if (issue && !ret) begin
      outstanding <= outstanding + CW'(1);
    end else if (!issue && ret) begin
      outstanding <= outstanding - CW'(1);
    end
  end

  // Tag FIFO pointers and occupancy
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tag_cnt <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tag_cnt <= '0;
    end else begin
      if (issue) wr_ptr <= wr_ptr + PW'(1);
      if (ret)   rd_ptr <= rd_ptr + PW'(1);
      if (issue && !ret)      tag_cnt <= tag_cnt + CW'(1);
      else if (!issue && ret) tag_cnt <= tag_cnt - CW'(1);
    end
  end

  // Tag FIFO storage: requester id of each issued beat
  always_ff @(posedge clk) begin
    if (issue) tag_mem[wr_ptr] <= grant;
  end

endmodule

// File: tb/tb_divide_share_arb.sv
// Directed bench for divide_share_arb with a behavioural in-order divider
// (fixed latency) and per-lane result scoreboards.
module tb_divide_share_arb;

  localparam int LAT = 8;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        clear = 1'b0;
  logic [95:0] s_tdata = '0;
  logic [1:0]  s_tlast = '0, s_tvalid = '0, s_tready;
  logic [15:0] div_dividend_tdata;
  logic [31:0] div_divisor_tdata;
  logic        div_tlast, div_tvalid;
  logic        div_dividend_tready = 1'b1, div_divisor_tready = 1'b1;
  logic [47:0] dout_tdata = '0;
  logic        dout_tlast = 1'b0, dout_tvalid = 1'b0, dout_tready;
  logic [47:0] m_tdata;
  logic        m_tlast;
  logic [1:0]  m_tvalid;
  logic [1:0]  m_tready = 2'b11;
  logic [4:0]  outstanding;
  logic        busy;

  divide_share_arb #(.NUM_REQ(2), .MAX_OUTSTANDING(16), .DIVIDEND_W(16),
                     .DIVISOR_W(32), .QUOT_W(48)) dut (
    .clk(clk), .aresetn(aresetn), .clear(clear),
    .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .div_dividend_tdata(div_dividend_tdata), .div_divisor_tdata(div_divisor_tdata),
    .div_tlast(div_tlast), .div_tvalid(div_tvalid),
    .div_dividend_tready(div_dividend_tready), .div_divisor_tready(div_divisor_tready),
    .dout_tdata(dout_tdata), .dout_tlast(dout_tlast), .dout_tvalid(dout_tvalid),
    .dout_tready(dout_tready),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .outstanding(outstanding), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] dvd; logic [31:0] dvs; logic last; } beat_t;
  typedef struct { logic [47:0] q; logic last; } res_t;
  typedef struct { logic [47:0] q; logic last; int unsigned due; } pipe_t;

  beat_t rq0[$], rq1[$];
  res_t  exp0[$], exp1[$];
  pipe_t pipe[$];
  int unsigned issue_lane[$];
  int unsigned issue_cyc[$];

  int unsigned n_checks = 0, n_fail = 0;
  int unsigned cyc = 0, peak = 0, dropped = 0, out_cnt0 = 0, out_cnt1 = 0;
  logic        flushing = 1'b0;
  logic [1:0]  iss_f = '0;
  logic        dacc = 1'b0, dret = 1'b0;
  logic [15:0] cap_dvd;
  logic [31:0] cap_dvs;
  logic        cap_last;

  function automatic logic [47:0] quot(input logic [15:0] a, input logic [31:0] b);
    logic [47:0] num;
    num = {a, 32'h0};
    return num / {16'h0, b};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    s_tvalid[0] = (rq0.size() != 0);
    s_tlast[0]  = (rq0.size() != 0) ? rq0[0].last : 1'b0;
    if (rq0.size() != 0) s_tdata[47:0] = {rq0[0].dvd, rq0[0].dvs};
    s_tvalid[1] = (rq1.size() != 0);
    s_tlast[1]  = (rq1.size() != 0) ? rq1[0].last : 1'b0;
    if (rq1.size() != 0) s_tdata[95:48] = {rq1[0].dvd, rq1[0].dvs};
    dout_tvalid = (pipe.size() != 0) && (pipe[0].due <= cyc);
    dout_tdata  = (pipe.size() != 0) ? pipe[0].q : '0;
    dout_tlast  = (pipe.size() != 0) ? pipe[0].last : 1'b0;
  endtask

  task automatic load(input int unsigned r, input int unsigned n);
    beat_t b;
    for (int unsigned k = 0; k < n; k++) begin
      b.dvd  = 16'($urandom);
      b.dvs  = $urandom | 32'h1;
      b.last = (k == n - 1);
      if (r == 0) rq0.push_back(b); else rq1.push_back(b);
    end
    drive();
  endtask

  task automatic step(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle(input string tag, input int unsigned budget);
    int unsigned n;
    n = 0;
    while (!(rq0.size() == 0 && rq1.size() == 0 && exp0.size() == 0 &&
             exp1.size() == 0 && pipe.size() == 0 && busy === 1'b0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_timeout"}, 64'(n < budget), 64'(1));
  endtask

  task automatic clear_model();
    rq0.delete(); rq1.delete(); exp0.delete(); exp1.delete(); pipe.delete();
    drive();
  endtask

  // Sample handshakes mid-cycle; scoreboard pushes on issue, pops on result
  always @(negedge clk) begin
    if (aresetn) begin
      if (s_tvalid[0] && s_tready[0]) begin
        iss_f[0] = 1'b1;
        exp0.push_back('{quot(rq0[0].dvd, rq0[0].dvs), rq0[0].last});
        issue_lane.push_back(0);
        issue_cyc.push_back(cyc);
      end
      if (s_tvalid[1] && s_tready[1]) begin
        iss_f[1] = 1'b1;
        exp1.push_back('{quot(rq1[0].dvd, rq1[0].dvs), rq1[0].last});
        issue_lane.push_back(1);
        issue_cyc.push_back(cyc);
      end
      dacc = div_tvalid && div_dividend_tready && div_divisor_tready;
      if (dacc) begin
        cap_dvd = div_dividend_tdata; cap_dvs = div_divisor_tdata; cap_last = div_tlast;
      end
      dret = dout_tvalid && dout_tready;
      if (flushing) begin
        check("flush_m_tvalid", 64'(m_tvalid), 64'(0));
        if (dret) dropped++;
      end else begin
        if (m_tvalid[0] && m_tready[0]) begin
          if (exp0.size() == 0) check("lane0_unexpected", 64'(m_tvalid[0]), 64'(0));
          else begin
            res_t e;
            e = exp0.pop_front();
            check("lane0_data", 64'(m_tdata), 64'(e.q));
            check("lane0_last", 64'(m_tlast), 64'(e.last));
            out_cnt0++;
          end
        end
        if (m_tvalid[1] && m_tready[1]) begin
          if (exp1.size() == 0) check("lane1_unexpected", 64'(m_tvalid[1]), 64'(0));
          else begin
            res_t e;
            e = exp1.pop_front();
            check("lane1_data", 64'(m_tdata), 64'(e.q));
            check("lane1_last", 64'(m_tlast), 64'(e.last));
            out_cnt1++;
          end
        end
      end
      if (32'(outstanding) > peak) peak = 32'(outstanding);
    end
  end

  // Commit handshakes after the edge: requester queues and divider pipeline
  always @(posedge clk) begin
    cyc++;
    #1;
    if (!aresetn) begin
      pipe.delete();
    end else begin
      if (iss_f[0]) rq0.delete(0);
      if (iss_f[1]) rq1.delete(0);
      if (dret) pipe.delete(0);
      if (dacc) pipe.push_back('{quot(cap_dvd, cap_dvs), cap_last, cyc + LAT});
    end
    iss_f = '0; dacc = 1'b0; dret = 1'b0;
    drive();
  end

  initial begin
    int unsigned load_cyc, n, c0;
    int unsigned exp_ord[9];
    exp_ord = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
    drive();
    #3;
    check("rst_s_tready", 64'(s_tready), 64'(0));
    check("rst_div_tvalid", 64'(div_tvalid), 64'(0));
    check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_dout_tready", 64'(dout_tready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_outstanding", 64'(outstanding), 64'(0));
    step(2);
    aresetn = 1'b1;
    step(2);

    // Single requester, 4-beat packet
    peak = 0;
    load_cyc = cyc;
    load(0, 4);
    wait_idle("t1", 60);
    check("t1_issues", 64'(issue_lane.size()), 64'(4));
    if (issue_cyc.size() == 4) begin
      check("t1_first_issue", 64'(issue_cyc[0]), 64'(load_cyc + 1));
      check("t1_consecutive", 64'(issue_cyc[3] - issue_cyc[0]), 64'(3));
    end
    check("t1_peak", 64'(peak), 64'(4));
    check("t1_out0", 64'(out_cnt0), 64'(4));
    check("t1_out1", 64'(out_cnt1), 64'(0));
    check("t1_outstanding", 64'(outstanding), 64'(0));

    // Both requesters from reset: packet-locked round robin
    @(posedge clk); #1;
    aresetn = 1'b0;
    clear_model();
    step(2);
    aresetn = 1'b1;
    step(1);
    issue_lane.delete(); issue_cyc.delete();
    out_cnt0 = 0; out_cnt1 = 0;
    load(0, 3); load(0, 3); load(1, 3);
    wait_idle("t2", 80);
    check("t2_issues", 64'(issue_lane.size()), 64'(9));
    for (int unsigned i = 0; i < 9 && i < issue_lane.size(); i++)
      check($sformatf("t2_order%0d", i), 64'(issue_lane[i]), 64'(exp_ord[i]));
    check("t2_out0", 64'(out_cnt0), 64'(6));
    check("t2_out1", 64'(out_cnt1), 64'(3));

    // Credit exhaustion with results stalled
    issue_lane.delete(); issue_cyc.delete();
    m_tready = 2'b00;
    peak = 0;
    load(0, 20);
    step(30);
    check("t3_issues_stalled", 64'(issue_lane.size()), 64'(16));
    check("t3_div_tvalid", 64'(div_tvalid), 64'(0));
    check("t3_outstanding", 64'(outstanding), 64'(16));
    check("t3_busy", 64'(busy), 64'(1));
    m_tready = 2'b11;
    step(3);
    check("t3_refill_outstanding", 64'(outstanding), 64'(15));
    check("t3_refill_issues", 64'(issue_lane.size()), 64'(18));
    wait_idle("t3", 80);
    check("t3_issues_total", 64'(issue_lane.size()), 64'(20));
    check("t3_peak", 64'(peak), 64'(16));

    // Head-of-line: requester 1 result stalled at the head
    issue_lane.delete(); issue_cyc.delete();
    out_cnt0 = 0; out_cnt1 = 0;
    m_tready = 2'b01;
    load(1, 1); load(0, 2);
    step(20);
    check("t4_dout_tvalid", 64'(dout_tvalid), 64'(1));
    check("t4_dout_tready", 64'(dout_tready), 64'(0));
    check("t4_m_tvalid", 64'(m_tvalid), 64'(2'b10));
    check("t4_lane0_held", 64'(out_cnt0), 64'(0));
    check("t4_outstanding", 64'(outstanding), 64'(3));
    m_tready = 2'b11;
    wait_idle("t4", 40);
    check("t4_out0", 64'(out_cnt0), 64'(2));
    check("t4_out1", 64'(out_cnt1), 64'(1));

    // Clear with 5 beats in flight
    m_tready = 2'b00;
    load(0, 5);
    n = 0;
    while (outstanding != 5'd5 && n < 30) begin step(1); n++; end
    check("t5_inflight", 64'(outstanding), 64'(5));
    flushing = 1'b1;
    dropped = 0;
    m_tready = 2'b11;
    clear = 1'b1;
    exp0.delete(); exp1.delete();
    step(1);
    clear = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 40) begin step(1); n++; end
    check("t5_flush_timeout", 64'(n < 40), 64'(1));
    check("t5_dropped", 64'(dropped), 64'(5));
    check("t5_outstanding", 64'(outstanding), 64'(0));
    check("t5_busy", 64'(busy), 64'(0));
    flushing = 1'b0;
    issue_lane.delete(); issue_cyc.delete();
    c0 = out_cnt1;
    load(1, 2);
    wait_idle("t5", 40);
    check("t5_next_issues", 64'(issue_lane.size()), 64'(2));
    check("t5_next_out1", 64'(out_cnt1 - c0), 64'(2));

    // Async reset mid-packet, then arbitration restarts at requester 0
    issue_lane.delete(); issue_cyc.delete();
    load(0, 1);
    wait_idle("t6a", 40);
    load(1, 8);
    n = 0;
    while (issue_lane.size() < 4 && n < 30) begin step(1); n++; end
    check("t6_midpacket", 64'(issue_lane.size()), 64'(4));
    @(posedge clk); #2;
    aresetn = 1'b0;
    #1;
    check("t6_s_tready", 64'(s_tready), 64'(0));
    check("t6_div_tvalid", 64'(div_tvalid), 64'(0));
    check("t6_m_tvalid", 64'(m_tvalid), 64'(0));
    check("t6_dout_tready", 64'(dout_tready), 64'(0));
    check("t6_busy", 64'(busy), 64'(0));
    check("t6_outstanding", 64'(outstanding), 64'(0));
    clear_model();
    step(2);
    aresetn = 1'b1;
    step(1);
    issue_lane.delete(); issue_cyc.delete();
    load(0, 1); load(1, 1);
    wait_idle("t6b", 40);
    check("t6_issues", 64'(issue_lane.size()), 64'(2));
    if (issue_lane.size() == 2) begin
      check("t6_first_grant", 64'(issue_lane[0]), 64'(0));
      check("t6_second_grant", 64'(issue_lane[1]), 64'(1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
